// File: rtl/fp_special_pkg.sv
// fp_special_pkg
//   Shared definitions for the special-value front end of the sqrt datapath.
//   - fp_class_e   : operand class code carried on out_class
//   - entry_hdr_t  : width-independent head of a pipeline entry
//                    (class, bypass, sign); the exponent/fraction/lz tail
//                    depends on module parameters and is added by the user
//   - qbit_mask()  : quiet-bit (fraction MSB) mask for a given fraction width
package fp_special_pkg;

    typedef enum logic [2:0] {
        ZERO      = 3'd0,
        SUBNORMAL = 3'd1,
        NORMAL    = 3'd2,
        PINF      = 3'd3,
        NINF      = 3'd4,
        NAN       = 3'd5
    } fp_class_e;

    typedef struct packed {
        fp_class_e cls;
        logic      bypass;
        logic      sign;
    } entry_hdr_t;

    localparam int MAX_MANT_W = 64;

    // One-hot mask of the fraction MSB; callers size-cast to their MANT_W.
    function automatic logic [MAX_MANT_W-1:0] qbit_mask(input int mant_w);
        logic [MAX_MANT_W-1:0] m;
        m = '0;
        m[mant_w-1] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/fp_skid_buf.sv
// fp_skid_buf
//   Generic 2-entry valid/ready skid buffer: an output register plus one
//   skid register. Order is preserved; the skid entry always drains into the
//   output register before any newer input can be taken.
// Handshake: a transfer happens on a side at a rising edge where valid and
//   ready are both high; valid never depends on ready on the same side.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready = skid not full)
//   in_data [W]         upstream payload
//   out_valid/out_ready downstream handshake
//   out_data [W]        downstream payload, held while out_valid && !out_ready
module fp_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         skid_full_q;
    logic [W-1:0] skid_data_q;
    logic         in_fire;

    assign in_ready  = !skid_full_q;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
        end else if (!out_valid_q || out_ready) begin
            // Output register is free this edge. A full skid refills it
            // first; in_ready is low then, so no new entry can collide.
            if (skid_full_q) begin
                out_data_q  <= skid_data_q;
                out_valid_q <= 1'b1;
                skid_full_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) begin
                    out_data_q <= in_data;
                end
            end
        end else if (in_fire) begin
            // Output stalled: park the new entry behind it.
            skid_data_q <= in_data;
            skid_full_q <= 1'b1;
        end
    end

endmodule

// File: rtl/fp_special_pipe.sv
// fp_special_pipe
//   Special-value front end for the sqrt datapath. Classifies an IEEE-754
//   operand of any EXP_W/MANT_W format and, in sqrt mode, produces the
//   early-out result (NaN, +inf, signed zero) with bypass=1. Positive finite
//   operands pass through unchanged for the sqrt core. mode=1 only classifies.
//   One cycle latency behind a 2-entry skid buffer.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   enable                    0 holds in_ready low; output side still drains
//   in_valid/in_ready         upstream handshake
//   mode                      0 sqrt early-out, 1 classify-only
//   in_sign/in_exp/in_mant    operand fields
//   out_valid/out_ready       downstream handshake
//   out_class/out_bypass      class code, result-is-final flag
//   out_sign/out_exp/out_mant result fields
//   out_lz                    leading zeros of the fraction for SUBNORMAL
//   flag_clr/flag_nv          clear / sticky invalid-operation flag
module fp_special_pipe
    import fp_special_pkg::*;
#(
    parameter  int EXP_W  = 5,
    parameter  int MANT_W = 10,
    localparam int LZ_W   = $clog2(MANT_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output fp_class_e         out_class,
    output logic              out_bypass,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic [LZ_W-1:0]   out_lz,
    input  logic              flag_clr,
    output logic              flag_nv
);

    localparam logic [MANT_W-1:0] QBIT = MANT_W'(qbit_mask(MANT_W));

    // Field widths follow the module parameters, so the full entry is
    // assembled here around the package header.
    typedef struct packed {
        entry_hdr_t         hdr;
        logic [EXP_W-1:0]   exp;
        logic [MANT_W-1:0]  mant;
        logic [LZ_W-1:0]    lz;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic               exp_zero;
    logic               exp_max;
    logic               mant_zero;
    fp_class_e          raw_class;
    logic [LZ_W-1:0]    lz_cnt;
    logic               lz_found;
    entry_t             entry;
    logic               nv_op;
    logic               buf_in_ready;
    logic               accept;
    logic [ENTRY_W-1:0] buf_out_data;
    entry_t             out_entry;

    assign exp_zero  = (in_exp == '0);
    assign exp_max   = &in_exp;
    assign mant_zero = (in_mant == '0);

    always_comb begin
        if (exp_zero) begin
            raw_class = mant_zero ? ZERO : SUBNORMAL;
        end else if (exp_max) begin
            raw_class = mant_zero ? (in_sign ? NINF : PINF) : NAN;
        end else begin
            raw_class = NORMAL;
        end
    end

    // Leading-zero count from the fraction MSB down; only consumed for
    // subnormals, where the fraction is nonzero so the count is < MANT_W.
    always_comb begin
        lz_cnt   = '0;
        lz_found = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (in_mant[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz_cnt = lz_cnt + LZ_W'(1);
                end
            end
        end
    end

    always_comb begin
        entry.hdr.cls    = raw_class;
        entry.hdr.bypass = 1'b0;
        entry.hdr.sign   = in_sign;
        entry.exp        = in_exp;
        entry.mant       = in_mant;
        entry.lz         = '0;
        nv_op            = 1'b0;
        if (!mode) begin
            case (raw_class)
                NAN: begin
                    // Quieten; a signalling NaN raises invalid.
                    entry.hdr.bypass = 1'b1;
                    entry.mant       = in_mant | QBIT;
                    nv_op            = !in_mant[MANT_W-1];
                end
                ZERO, PINF: begin
                    entry.hdr.bypass = 1'b1;
                end
                default: begin
                    // NINF, or a negative normal/subnormal: sqrt is invalid.
                    if (in_sign) begin
                        entry.hdr.cls    = NAN;
                        entry.hdr.bypass = 1'b1;
                        entry.hdr.sign   = 1'b1;
                        entry.exp        = '1;
                        entry.mant       = QBIT;
                        nv_op            = 1'b1;
                    end
                end
            endcase
        end
        if (entry.hdr.cls == SUBNORMAL) begin
            entry.lz = lz_cnt;
        end
    end

    assign in_ready = enable && buf_in_ready;
    assign accept   = in_valid && in_ready;

    fp_skid_buf #(
        .W (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && enable),
        .in_ready  (buf_in_ready),
        .in_data   (entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out_data)
    );

    assign out_entry  = buf_out_data;
    assign out_class  = out_entry.hdr.cls;
    assign out_bypass = out_entry.hdr.bypass;
    assign out_sign   = out_entry.hdr.sign;
    assign out_exp    = out_entry.exp;
    assign out_mant   = out_entry.mant;
    assign out_lz     = out_entry.lz;

    // Raised when the invalid operand is accepted, not when it leaves;
    // a set in the same cycle wins over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_nv <= 1'b0;
        end else if (accept && nv_op) begin
            flag_nv <= 1'b1;
        end else if (flag_clr) begin
            flag_nv <= 1'b0;
        end
    end

endmodule
